// File: rtl/sram_audio_ctrl_pkg.sv
// Shared types and defaults for the audio SRAM sequencing controller.
package sram_audio_ctrl_pkg;
    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;
    localparam logic [DEF_ADDR_W-1:0] MAX_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC_WAIT,
        S_REC_WR,
        S_PLAY_WAIT,
        S_PLAY_RD,
        S_CLEAR
    } state_t;
endpackage

// File: rtl/sram_audio_ctrl_timer.sv
// Down-counter that times one SRAM word access and flags its final cycle.
module sram_access_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] load,
    output logic             last
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            cnt_d = load;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) run_d = 1'b0;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign last = run_q && (cnt_q == '0);
endmodule

// File: rtl/sram_audio_ctrl.sv
// Record/play/clear sequencer in front of the audio SRAM wrapper.
// Owns the address counter, recorded length and clear sweep; all outputs registered.
import sram_audio_ctrl_pkg::*;

module sram_audio_ctrl #(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_record,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic              cmd_clear,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              dac_ready,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_read,
    output logic              sram_write,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] end_addr
);
    localparam int MAXC  = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [ADDR_W-1:0] MAX_A = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d, addr_inc;
    logic [DATA_W-1:0] wdata_q, wdata_d, dout_q, dout_d;
    logic              rd_q, rd_d, wr_q, wr_d, dv_q, dv_d, ovr_q, ovr_d;
    logic              busy_q, busy_d, stop_pend_q, stop_pend_d;
    logic              t_start, t_last;
    logic [CNT_W-1:0]  t_load;

    sram_access_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (reset),
        .start (t_start),
        .load  (t_load),
        .last  (t_last)
    );

    assign addr_inc = addr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        end_d       = end_q;
        wdata_d     = wdata_q;
        dout_d      = dout_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        dv_d        = 1'b0;
        ovr_d       = 1'b0;
        stop_pend_d = stop_pend_q;
        t_start     = 1'b0;
        t_load      = '0;
        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (cmd_clear) begin
                    state_d = S_CLEAR;
                    addr_d  = '0;
                    end_d   = '0;
                    wdata_d = '0;
                end else if (cmd_record) begin
                    state_d = S_REC_WAIT;
                    addr_d  = '0;
                    end_d   = '0;
                end else if (cmd_play && end_q != '0) begin
                    state_d = S_PLAY_WAIT;
                    addr_d  = '0;
                end
            end
            S_REC_WAIT: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (adc_valid) begin
                    state_d = S_REC_WR;
                    wdata_d = adc_data;
                    wr_d    = 1'b1;
                    t_start = 1'b1;
                    t_load  = CNT_W'(WR_CYCLES - 1);
                end
            end
            S_REC_WR: begin
                ovr_d = adc_valid;
                if (cmd_stop) stop_pend_d = 1'b1;
                if (t_last) begin
                    wr_d  = 1'b0;
                    end_d = (addr_q == MAX_A) ? MAX_A : addr_inc;
                    // Full memory ends the take without wrapping back to 0.
                    if (addr_q == MAX_A) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_inc;
                        state_d = (stop_pend_q || cmd_stop) ? S_IDLE : S_REC_WAIT;
                    end
                end
            end
            S_PLAY_WAIT: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (dac_ready) begin
                    state_d = S_PLAY_RD;
                    rd_d    = 1'b1;
                    t_start = 1'b1;
                    t_load  = CNT_W'(RD_CYCLES - 1);
                end
            end
            S_PLAY_RD: begin
                ovr_d = dac_ready;
                if (cmd_stop) stop_pend_d = 1'b1;
                if (t_last) begin
                    rd_d    = 1'b0;
                    dout_d  = sram_rdata;
                    dv_d    = 1'b1;
                    addr_d  = addr_inc;
                    state_d = (addr_inc == end_q || stop_pend_q || cmd_stop) ? S_IDLE : S_PLAY_WAIT;
                end
            end
            S_CLEAR: begin
                if (cmd_stop) stop_pend_d = 1'b1;
                // Write low marks the gap cycle between words; a stop there exits at once.
                if (!wr_q) begin
                    if (stop_pend_q || cmd_stop) begin
                        state_d = S_IDLE;
                    end else begin
                        wr_d    = 1'b1;
                        t_start = 1'b1;
                        t_load  = CNT_W'(WR_CYCLES - 1);
                    end
                end else if (t_last) begin
                    wr_d = 1'b0;
                    if (addr_q == MAX_A || stop_pend_q || cmd_stop) state_d = S_IDLE;
                    else                                              addr_d  = addr_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            end_q       <= '0;
            wdata_q     <= '0;
            dout_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            dv_q        <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            end_q       <= end_d;
            wdata_q     <= wdata_d;
            dout_q      <= dout_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            dv_q        <= dv_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_read  = rd_q;
    assign sram_write = wr_q;
    assign sram_wdata = wdata_q;
    assign dac_data   = dout_q;
    assign dac_valid  = dv_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;
    assign end_addr   = end_q;
endmodule

// File: tb/tb_sram_audio_ctrl.sv
// Bench for sram_audio_ctrl: directed scenarios plus random traffic against a
// timeline-based behavioural model, compared every cycle on the falling edge.
module tb_sram_audio_ctrl;
    localparam int AW = 4, DW = 16, WRC = 2, RDC = 2;
    localparam int NW = 16, MAXA = 15;
    localparam int MI = 0, MR = 1, MP = 2, MC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, cmd_record, cmd_play, cmd_stop, cmd_clear, adc_valid, dac_ready;
    logic [DW-1:0] adc_data, dac_data, sram_wdata, sram_rdata;
    logic [AW-1:0] sram_addr, end_addr;
    logic dac_valid, sram_read, sram_write, busy, overrun;
    logic rd_is_addr;
    logic [DW-1:0] sram_mem [NW];

    sram_audio_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WRC), .RD_CYCLES(RDC)) dut (
        .clk(clk), .reset(reset), .cmd_record(cmd_record), .cmd_play(cmd_play),
        .cmd_stop(cmd_stop), .cmd_clear(cmd_clear), .adc_valid(adc_valid), .adc_data(adc_data),
        .dac_ready(dac_ready), .dac_data(dac_data), .dac_valid(dac_valid),
        .sram_addr(sram_addr), .sram_read(sram_read), .sram_write(sram_write),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy), .overrun(overrun),
        .end_addr(end_addr)
    );

    // Simple wrapper model: either real storage or address-as-data readback.
    always @(posedge clk) if (sram_write) sram_mem[sram_addr] <= sram_wdata;
    assign sram_rdata = rd_is_addr ? DW'(sram_addr) : sram_mem[sram_addr];

    // Behavioural model: accesses are time windows opened at the accepting edge.
    int k, t0, c0, r, mmode, m_addr, m_end;
    bit job_on, stop_req, e_dv, e_ovr, e_wr, e_rd;
    logic [DW-1:0] m_wdata, e_dd;
    logic [DW-1:0] mmem [NW];

    function automatic bit cgap(int rr);
        return (rr == 0) || (((rr - 1) % (WRC + 1)) == WRC);
    endfunction
    function automatic int caddr(int rr);
        if (rr == 0) return 0;
        return (rr - 1) / (WRC + 1) + ((((rr - 1) % (WRC + 1)) == WRC) ? 1 : 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mmode = MI; job_on = 0; stop_req = 0; m_addr = 0; m_end = 0;
            m_wdata = '0; e_dd = '0; e_dv = 0; e_ovr = 0; e_wr = 0; e_rd = 0; k = 0;
        end else begin
            k++; e_dv = 0; e_ovr = 0;
            case (mmode)
                MI: begin
                    if (cmd_stop) ;
                    else if (cmd_clear) begin mmode = MC; c0 = k; m_addr = 0; m_end = 0; m_wdata = '0; stop_req = 0; end
                    else if (cmd_record) begin mmode = MR; m_addr = 0; m_end = 0; job_on = 0; stop_req = 0; end
                    else if (cmd_play && m_end != 0) begin mmode = MP; m_addr = 0; job_on = 0; stop_req = 0; end
                end
                MR, MP: begin
                    if (!job_on) begin
                        if (cmd_stop) mmode = MI;
                        else if (mmode == MR && adc_valid) begin job_on = 1; t0 = k; m_wdata = adc_data; end
                        else if (mmode == MP && dac_ready) begin job_on = 1; t0 = k; end
                    end else begin
                        e_ovr = (mmode == MR) ? adc_valid : dac_ready;
                        stop_req |= cmd_stop;
                        if (k == t0 + ((mmode == MR) ? WRC : RDC)) begin
                            job_on = 0;
                            if (mmode == MR) begin
                                mmem[m_addr] = m_wdata;
                                m_end = (m_addr == MAXA) ? MAXA : m_addr + 1;
                                if (m_addr == MAXA) mmode = MI;
                                else begin m_addr++; if (stop_req) mmode = MI; end
                            end else begin
                                e_dv = 1;
                                e_dd = rd_is_addr ? DW'(m_addr) : mmem[m_addr];
                                m_addr++;
                                if (m_addr == m_end || stop_req) mmode = MI;
                            end
                        end
                    end
                end
                MC: begin
                    r = k - c0;
                    if (cmd_stop && cgap(r - 1)) mmode = MI;
                    else if (cgap(r) && (stop_req || cmd_stop || r == NW * (WRC + 1))) begin
                        mmem[caddr(r - 1)] = '0; mmode = MI;
                    end else begin
                        if (cgap(r) && !cgap(r - 1)) mmem[caddr(r - 1)] = '0;
                        stop_req |= cmd_stop;
                        m_addr = caddr(r);
                    end
                end
                default: mmode = MI;
            endcase
            e_wr = (mmode == MR && job_on) || (mmode == MC && !cgap(k - c0));
            e_rd = (mmode == MP && job_on);
        end
    end

    int errors = 0, checks = 0;
    int wr_cnt, dv_cnt, ovr_cnt, busy_cnt;
    logic [DW-1:0] last_dd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        cmd_record = 0; cmd_play = 0; cmd_stop = 0; cmd_clear = 0; adc_valid = 0; dac_ready = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_cnt();
        wr_cnt = 0; dv_cnt = 0; ovr_cnt = 0; busy_cnt = 0;
    endtask

    initial begin
        reset = 1; rd_is_addr = 0; adc_data = '0;
        cmd_record = 0; cmd_play = 0; cmd_stop = 0; cmd_clear = 0; adc_valid = 0; dac_ready = 0;
        clr_cnt(); last_dd = '0;
        fork
            forever begin
                @(negedge clk);
                chk("sram_addr", 32'(sram_addr), 32'(m_addr[AW-1:0]));
                chk("sram_write", 32'(sram_write), 32'(e_wr));
                chk("sram_read", 32'(sram_read), 32'(e_rd));
                chk("sram_wdata", 32'(sram_wdata), 32'(m_wdata));
                chk("dac_valid", 32'(dac_valid), 32'(e_dv));
                chk("dac_data", 32'(dac_data), 32'(e_dd));
                chk("busy", 32'(busy), 32'(mmode != MI));
                chk("overrun", 32'(overrun), 32'(e_ovr));
                chk("end_addr", 32'(end_addr), 32'(m_end));
                if (sram_write) wr_cnt++;
                if (dac_valid) begin dv_cnt++; last_dd = dac_data; end
                if (overrun) ovr_cnt++;
                if (busy) busy_cnt++;
            end
        join_none

        steps(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_end_addr", 32'(end_addr), 32'd0);
        chk("rst_dac_valid", 32'(dac_valid), 32'd0);
        reset = 0;
        step();

        // Record 1..5, eight cycles apart, then stop.
        clr_cnt();
        cmd_record = 1; step();
        for (int i = 1; i <= 5; i++) begin
            adc_valid = 1; adc_data = DW'(i); step(); steps(7);
        end
        cmd_stop = 1; step(); step();
        chk("rec_end_addr", 32'(end_addr), 32'd5);
        chk("model_end", 32'(m_end), 32'd5);
        chk("rec_wr_cycles", 32'(wr_cnt), 32'd10);
        chk("rec_mem0", 32'(sram_mem[0]), 32'h1);
        chk("rec_mem4", 32'(sram_mem[4]), 32'h5);

        // Play with address-as-data readback; sixth strobe lands in IDLE.
        clr_cnt(); rd_is_addr = 1;
        cmd_play = 1; step();
        for (int i = 0; i < 6; i++) begin dac_ready = 1; step(); steps(7); end
        chk("play_dv_count", 32'(dv_cnt), 32'd5);
        chk("play_last_data", 32'(last_dd), 32'd4);
        chk("play_idle", 32'(busy), 32'd0);
        rd_is_addr = 0;

        // Back-to-back adc strobes: second one is an overrun.
        clr_cnt();
        cmd_record = 1; step();
        adc_valid = 1; adc_data = 16'hAAAA; step();
        adc_valid = 1; adc_data = 16'hBBBB; step();
        steps(5);
        cmd_stop = 1; step(); step();
        chk("ovr_count", 32'(ovr_cnt), 32'd1);
        chk("ovr_end_addr", 32'(end_addr), 32'd1);
        chk("ovr_mem0", 32'(sram_mem[0]), 32'hAAAA);

        // Full clear sweep.
        clr_cnt();
        cmd_clear = 1; step();
        for (int i = 0; i < 200 && busy; i++) step();
        chk("clear_done", 32'(busy), 32'd0);
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd48);
        chk("clear_words", 32'(wr_cnt), 32'd32);
        chk("clear_end_addr", 32'(end_addr), 32'd0);
        chk("clear_mem0", 32'(sram_mem[0]), 32'h0);
        cmd_play = 1; step(); step();
        chk("play_after_clear", 32'(busy), 32'd0);

        // Stop wins over record.
        cmd_stop = 1; cmd_record = 1; step(); step();
        chk("stop_beats_record", 32'(busy), 32'd0);

        // Record past the top of memory: end_addr saturates, no wrap.
        clr_cnt();
        cmd_record = 1; step();
        for (int i = 0; i < 17; i++) begin
            adc_valid = 1; adc_data = DW'(16'h100 + i); step(); steps(3);
        end
        chk("full_wr_cycles", 32'(wr_cnt), 32'd32);
        chk("full_end_addr", 32'(end_addr), 32'd15);
        chk("full_addr_nowrap", 32'(sram_addr), 32'd15);
        chk("full_idle", 32'(busy), 32'd0);
        chk("full_mem15", 32'(sram_mem[15]), 32'h10F);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            cmd_stop   = ($urandom_range(0, 199) < 2);
            cmd_clear  = ($urandom_range(0, 999) < 3);
            cmd_record = ($urandom_range(0, 99) < 3);
            cmd_play   = ($urandom_range(0, 99) < 4);
            adc_valid  = ($urandom_range(0, 99) < 30);
            dac_ready  = ($urandom_range(0, 99) < 30);
            adc_data   = DW'($urandom);
            @(posedge clk); #1;
        end
        step();

        // Reset in the middle of a write.
        cmd_stop = 1; step(); steps(4);
        cmd_record = 1; step();
        adc_valid = 1; adc_data = 16'h5A5A; step();
        chk("pre_rst_write", 32'(sram_write), 32'd1);
        reset = 1; #1;
        chk("mid_rst_write", 32'(sram_write), 32'd0);
        chk("mid_rst_wdata", 32'(sram_wdata), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(sram_addr), 32'd0);
        steps(2);
        reset = 0;
        steps(2);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_end", 32'(end_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
